par2ser_stream: RTL and testbench

Parametrised parallel-to-serial converter with valid/ready handshakes on both sides. It is the next generation of the team's fixed 16-to-2 serializer. It adds configurable word and symbol widths, selectable bit order, and backpressure. A one-word holding buffer gives back-to-back streaming with no bubbles, and frame markers are carried through to the output. It sits between the sample/packet word path and symbol-rate consumers such as the modulator mapper and scrambler.

---
 rtl/par2ser_stream_pkg.sv | 27 ++
 rtl/par2ser_stream_if.sv | 39 +++
 rtl/par2ser_stream_hold_buf.sv | 45 ++++
 rtl/par2ser_stream.sv | 128 ++++++++++++
 tb/tb_par2ser_stream.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/par2ser_stream_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the par2ser_stream serializer:
//   - symbol-order encoding constants for the MSB_FIRST parameter
//   - nsym()     : number of symbols per parallel word
//   - cnt_w()    : width of the symbol counter (never less than 1 bit)
//   - width_ok() : legality check on the word/symbol width pair
// ---------------------------------------------------------------------------
package ser_pkg;

  localparam int ORDER_LSB_FIRST = 0;
  localparam int ORDER_MSB_FIRST = 1;

  function automatic int nsym(input int data_w, input int sym_w);
    return data_w / sym_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A word must split into a whole number of symbols, each at least one bit.
  function automatic bit width_ok(input int data_w, input int sym_w);
    return (sym_w >= 1) && (sym_w <= data_w) && ((data_w % sym_w) == 0);
  endfunction

endpackage

// File: rtl/par2ser_stream_if.sv
// ---------------------------------------------------------------------------
// par2ser_stream_if
// Stream bundle around the serializer.
//   flush                         : synchronous clear request
//   in_valid/in_ready/in_data/in_last    : word-side handshake
//   out_valid/out_ready/out_sym/out_first/out_last : symbol-side handshake
//   busy                          : serializer holds data
// Modports:
//   master : the environment (drives words, consumes symbols)
//   slave  : the serializer itself
// ---------------------------------------------------------------------------
interface par2ser_stream_if #(
  parameter int DATA_W = 16,
  parameter int SYM_W  = 2
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SYM_W-1:0]  out_sym;
  logic              out_first;
  logic              out_last;
  logic              busy;

  modport master (
    output flush, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_first, out_last, busy
  );

  modport slave (
    input  flush, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_first, out_last, busy
  );

endinterface

// File: rtl/par2ser_stream_hold_buf.sv
// ---------------------------------------------------------------------------
// ser_hold_buf
// Single-entry holding register for {data, last} with a valid flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous empty (wins over load/take)
//   load                : capture load_data/load_last, become valid
//   take                : entry consumed, become empty
//   load_data/load_last : word being parked
//   valid/data/last     : current contents
// load and take never coincide: the owner only loads while empty and
// only takes while full.
// ---------------------------------------------------------------------------
module ser_hold_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              take,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/par2ser_stream.sv
// ---------------------------------------------------------------------------
// par2ser_stream
// Parallel-to-serial converter with valid/ready on both sides. A shift
// stage S emits one SYM_W symbol per output handshake; a one-word holding
// buffer H lets the next word wait so words stream back-to-back.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : par2ser_stream_if.slave (word input, symbol output, flush, busy)
// Parameters:
//   DATA_W    : word width (multiple of SYM_W)
//   SYM_W     : symbol width
//   MSB_FIRST : ORDER_MSB_FIRST emits the top symbol first, else the bottom
// ---------------------------------------------------------------------------
module par2ser_stream
  import ser_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SYM_W     = 2,
  parameter int MSB_FIRST = ORDER_MSB_FIRST
) (
  input logic             clk,
  input logic             rst_n,
  par2ser_stream_if.slave bus
);

  localparam int NSYM = nsym(DATA_W, SYM_W);
  localparam int CW   = cnt_w(NSYM);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSYM - 1);

  if (!width_ok(DATA_W, SYM_W)) begin : g_bad_width
    $error("par2ser_stream: DATA_W must be a positive multiple of SYM_W");
  end

  logic [DATA_W-1:0] s_data;
  logic [CW-1:0]     cnt;
  logic              sv;
  logic              sl;
  logic [DATA_W-1:0] h_data;
  logic              hv;
  logic              hl;
  logic              in_fire;
  logic              out_fire;
  logic              at_last;
  logic              s_frees;
  logic              h_to_s;
  logic              in_to_s;
  logic              in_to_h;
  logic [SYM_W-1:0]  sym_sel;

  // in_fire implies H is empty, so an H->S move and a direct input load
  // can never both be requested in one cycle.
  assign bus.in_ready = !hv && !bus.flush;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = sv && bus.out_ready;
  assign at_last      = (cnt == LAST_CNT);
  assign s_frees      = !sv || (out_fire && at_last);
  assign h_to_s       = hv && s_frees && !bus.flush;
  assign in_to_s      = in_fire && s_frees;
  assign in_to_h      = in_fire && !s_frees;

  ser_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.flush),
    .load      (in_to_h),
    .take      (h_to_s),
    .load_data (bus.in_data),
    .load_last (bus.in_last),
    .valid     (hv),
    .data      (h_data),
    .last      (hl)
  );

  // Shift stage: flush first, then refill from H, then from the input,
  // otherwise step through the word on each accepted symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data <= '0;
      cnt    <= '0;
      sv     <= 1'b0;
      sl     <= 1'b0;
    end else if (bus.flush) begin
      cnt    <= '0;
      sv     <= 1'b0;
      sl     <= 1'b0;
    end else if (h_to_s) begin
      s_data <= h_data;
      sl     <= hl;
      sv     <= 1'b1;
      cnt    <= '0;
    end else if (in_to_s) begin
      s_data <= bus.in_data;
      sl     <= bus.in_last;
      sv     <= 1'b1;
      cnt    <= '0;
    end else if (out_fire) begin
      if (at_last) begin
        sv  <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Constant-index mux keeps every part-select in range for any NSYM.
  always_comb begin
    sym_sel = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (cnt == CW'(i)) begin
        if (MSB_FIRST == ORDER_MSB_FIRST) begin
          sym_sel = s_data[DATA_W-1-i*SYM_W -: SYM_W];
        end else begin
          sym_sel = s_data[i*SYM_W +: SYM_W];
        end
      end
    end
  end

  assign bus.out_valid = sv;
  assign bus.out_sym   = sv ? sym_sel : '0;
  assign bus.out_first = sv && (cnt == '0);
  assign bus.out_last  = sv && sl && at_last;
  assign bus.busy      = sv || hv;

endmodule

// File: tb/tb_par2ser_stream.sv
// ---------------------------------------------------------------------------
// tb_par2ser_stream
// Directed bench for par2ser_stream. Four instances:
//   dut0 : 16/2 MSB first (main instance, driven directly)
//   dut1 : 16/2 LSB first (mirrors dut0 inputs)
//   dut2 : 12/4 MSB first
//   dut3 : 8/8  (one symbol per word)
// ---------------------------------------------------------------------------
module tb_par2ser_stream;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  par2ser_stream_if #(.DATA_W(16), .SYM_W(2)) if0 ();
  par2ser_stream_if #(.DATA_W(16), .SYM_W(2)) if1 ();
  par2ser_stream_if #(.DATA_W(12), .SYM_W(4)) if2 ();
  par2ser_stream_if #(.DATA_W(8),  .SYM_W(8)) if3 ();

  par2ser_stream #(.DATA_W(16), .SYM_W(2), .MSB_FIRST(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  par2ser_stream #(.DATA_W(16), .SYM_W(2), .MSB_FIRST(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  par2ser_stream #(.DATA_W(12), .SYM_W(4), .MSB_FIRST(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  par2ser_stream #(.DATA_W(8),  .SYM_W(8), .MSB_FIRST(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if1.flush     = if0.flush;
  assign if1.in_valid  = if0.in_valid;
  assign if1.in_data   = if0.in_data;
  assign if1.in_last   = if0.in_last;
  assign if1.out_ready = if0.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [1:0]  exp_sym;
    logic [1:0]  exp_sym_lsb;
    logic        exp_first;
    logic        exp_last;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Hand-derived symbol sequences: A5C3 = 10 10 01 01 11 00 00 11, 0F0F = 00 00 11 11 00 00 11 11
  logic [1:0] sym_a_msb [8] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3};
  logic [1:0] sym_a_lsb [8] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [1:0] sym_b_msb [8] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3};
  logic [1:0] sym_b_lsb [8] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [3:0] sym_abc   [3] = '{4'hA, 4'hB, 4'hC};

  logic [1:0] got_sym [$];
  logic       got_first [$];
  logic       got_last [$];
  logic       prev_stall;
  logic [1:0] prev_sym;
  logic       prev_first;
  logic       prev_last;

  function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic il, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic [1:0] e_sym,
                              input logic [1:0] e_lsb, input logic e_f, input logic e_l, input logic e_b);
    vec_t v;
    v.in_valid      = iv;
    v.in_data       = d;
    v.in_last       = il;
    v.out_ready     = ordy;
    v.exp_in_ready  = e_ir;
    v.exp_out_valid = e_ov;
    v.exp_sym       = e_sym;
    v.exp_sym_lsb   = e_lsb;
    v.exp_first     = e_f;
    v.exp_last      = e_l;
    v.exp_busy      = e_b;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [15:0] d, input logic il,
                               input logic ordy, input logic fl);
    if0.in_valid  = iv;
    if0.in_data   = d;
    if0.in_last   = il;
    if0.out_ready = ordy;
    if0.flush     = fl;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    applyStimulus(0, 16'h0, 0, 0, 0);
    if2.flush = 0; if2.in_valid = 0; if2.in_data = '0; if2.in_last = 0; if2.out_ready = 0;
    if3.flush = 0; if3.in_valid = 0; if3.in_data = '0; if3.in_last = 0; if3.out_ready = 0;

    // ---- reset state ----
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", if0.out_valid, 0);
    checkOutput("rst_out_sym",   if0.out_sym,   0);
    checkOutput("rst_out_first", if0.out_first, 0);
    checkOutput("rst_out_last",  if0.out_last,  0);
    checkOutput("rst_busy",      if0.busy,      0);
    checkOutput("rst_in_ready",  if0.in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single word (both orders) then back-to-back words ----
    vecs.push_back(mk(1, 16'hA5C3, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 16'h0, 0, 1, 1, 1, sym_a_msb[i], sym_a_lsb[i], i == 0, i == 7, 1));
    vecs.push_back(mk(0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'hA5C3, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0F0F, 1, 1, 1, 1, sym_a_msb[0], sym_a_lsb[0], 1, 0, 1));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(0, 16'h0, 0, 1, 0, 1, sym_a_msb[i], sym_a_lsb[i], 0, 0, 1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 16'h0, 0, 1, 1, 1, sym_b_msb[i], sym_b_lsb[i], i == 0, i == 7, 1));
    vecs.push_back(mk(0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      applyStimulus(vecs[k].in_valid, vecs[k].in_data, vecs[k].in_last, vecs[k].out_ready, 0);
      #1;
      checkOutput($sformatf("v%0d_in_ready", k),  if0.in_ready,  vecs[k].exp_in_ready);
      checkOutput($sformatf("v%0d_out_valid", k), if0.out_valid, vecs[k].exp_out_valid);
      checkOutput($sformatf("v%0d_first", k),     if0.out_first, vecs[k].exp_first);
      checkOutput($sformatf("v%0d_last", k),      if0.out_last,  vecs[k].exp_last);
      checkOutput($sformatf("v%0d_busy", k),      if0.busy,      vecs[k].exp_busy);
      checkOutput($sformatf("v%0d_lsb_valid", k), if1.out_valid, vecs[k].exp_out_valid);
      if (vecs[k].exp_out_valid) begin
        checkOutput($sformatf("v%0d_sym", k),     if0.out_sym, vecs[k].exp_sym);
        checkOutput($sformatf("v%0d_lsb_sym", k), if1.out_sym, vecs[k].exp_sym_lsb);
      end
    end

    // ---- backpressure with a third word offered while full ----
    prev_stall = 0;
    prev_sym   = 0;
    prev_first = 0;
    prev_last  = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (k == 0)                applyStimulus(1, 16'hA5C3, 1, 0, 0);
      else if (k == 1)           applyStimulus(1, 16'h0F0F, 0, 1, 0);
      else if (k >= 2 && k <= 5) applyStimulus(1, 16'h1234, 0, (k % 3) == 1, 0);
      else                       applyStimulus(0, 16'h0, 0, (k % 3) == 1, 0);
      #1;
      if (k >= 2 && k <= 5) checkOutput($sformatf("bp_refuse_k%0d", k), if0.in_ready, 0);
      if (prev_stall) begin
        checkOutput($sformatf("bp_hold_valid_k%0d", k), if0.out_valid, 1);
        checkOutput($sformatf("bp_hold_sym_k%0d", k),   if0.out_sym,   prev_sym);
        checkOutput($sformatf("bp_hold_first_k%0d", k), if0.out_first, prev_first);
        checkOutput($sformatf("bp_hold_last_k%0d", k),  if0.out_last,  prev_last);
      end
      if (if0.out_valid && if0.out_ready) begin
        got_sym.push_back(if0.out_sym);
        got_first.push_back(if0.out_first);
        got_last.push_back(if0.out_last);
      end
      prev_stall = if0.out_valid && !if0.out_ready;
      prev_sym   = if0.out_sym;
      prev_first = if0.out_first;
      prev_last  = if0.out_last;
      if (k > 5 && !if0.busy) break;
    end
    checkOutput("bp_drained", if0.busy, 0);
    checkOutput("bp_count", got_sym.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_sym.size()) begin
        checkOutput($sformatf("bp_sym%0d", i),   got_sym[i], (i < 8) ? sym_a_msb[i] : sym_b_msb[i-8]);
        checkOutput($sformatf("bp_first%0d", i), got_first[i], (i == 0) || (i == 8));
        checkOutput($sformatf("bp_last%0d", i),  got_last[i], i == 7);
      end
    end

    // ---- flush with H full and a concurrent input ----
    @(negedge clk); applyStimulus(1, 16'hA5C3, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 16'h0F0F, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); applyStimulus(0, 16'h0, 0, 1, 0);
    end
    @(negedge clk); applyStimulus(1, 16'h1234, 1, 1, 1);
    #1;
    checkOutput("fl_in_ready_during", if0.in_ready, 0);
    checkOutput("fl_sym_shown",       if0.out_sym,  sym_a_msb[3]);
    checkOutput("fl_busy_during",     if0.busy,     1);
    @(negedge clk); applyStimulus(0, 16'h0, 0, 1, 0);
    #1;
    checkOutput("fl_out_valid", if0.out_valid, 0);
    checkOutput("fl_busy",      if0.busy,      0);
    checkOutput("fl_in_ready",  if0.in_ready,  1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("fl_discard%0d", i), if0.out_valid, 0);
    end

    // ---- asynchronous reset mid-word ----
    @(negedge clk); applyStimulus(1, 16'hA5C3, 1, 1, 0);
    @(negedge clk); applyStimulus(0, 16'h0, 0, 1, 0);
    @(negedge clk);
    #1;
    checkOutput("mr_pre_valid", if0.out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_out_valid", if0.out_valid, 0);
    checkOutput("mr_out_sym",   if0.out_sym,   0);
    checkOutput("mr_out_first", if0.out_first, 0);
    checkOutput("mr_out_last",  if0.out_last,  0);
    checkOutput("mr_busy",      if0.busy,      0);
    checkOutput("mr_in_ready",  if0.in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 16'h0, 0, 1, 0);
    @(negedge clk);
    #1;
    checkOutput("mr_after_valid", if0.out_valid, 0);

    // ---- 12/4 MSB first: ABC -> A, B, C ----
    @(negedge clk);
    if2.in_valid = 1; if2.in_data = 12'hABC; if2.in_last = 1; if2.out_ready = 1;
    #1;
    checkOutput("w12_in_ready", if2.in_ready, 1);
    checkOutput("w12_idle",     if2.out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if2.in_valid = 0;
      #1;
      checkOutput($sformatf("w12_valid%0d", i), if2.out_valid, 1);
      checkOutput($sformatf("w12_sym%0d", i),   if2.out_sym,   sym_abc[i]);
      checkOutput($sformatf("w12_first%0d", i), if2.out_first, i == 0);
      checkOutput($sformatf("w12_last%0d", i),  if2.out_last,  i == 2);
    end
    @(negedge clk);
    #1;
    checkOutput("w12_done", if2.out_valid, 0);

    // ---- 8/8: each word is one symbol, first and last together ----
    @(negedge clk);
    if3.in_valid = 1; if3.in_data = 8'h5A; if3.in_last = 0; if3.out_ready = 1;
    @(negedge clk);
    if3.in_data = 8'hC3; if3.in_last = 1;
    #1;
    checkOutput("w8_in_ready", if3.in_ready, 1);
    checkOutput("w8_sym0",     if3.out_sym,  8'h5A);
    checkOutput("w8_first0",   if3.out_first, 1);
    checkOutput("w8_last0",    if3.out_last,  0);
    @(negedge clk);
    if3.in_valid = 0;
    #1;
    checkOutput("w8_sym1",   if3.out_sym,   8'hC3);
    checkOutput("w8_first1", if3.out_first, 1);
    checkOutput("w8_last1",  if3.out_last,  1);
    @(negedge clk);
    #1;
    checkOutput("w8_idle", if3.out_valid, 0);

    // ---- 8/8 as a 2-deep buffer under backpressure ----
    @(negedge clk);
    if3.in_valid = 1; if3.in_data = 8'h11; if3.in_last = 0; if3.out_ready = 0;
    @(negedge clk);
    if3.in_data = 8'h22;
    #1;
    checkOutput("d2_in_ready1", if3.in_ready, 1);
    checkOutput("d2_sym_a",     if3.out_sym,  8'h11);
    @(negedge clk);
    if3.in_data = 8'h33;
    #1;
    checkOutput("d2_refuse", if3.in_ready, 0);
    checkOutput("d2_busy",   if3.busy,     1);
    @(negedge clk);
    if3.in_valid = 0; if3.out_ready = 1;
    #1;
    checkOutput("d2_sym_b", if3.out_sym, 8'h11);
    @(negedge clk);
    #1;
    checkOutput("d2_sym_c",    if3.out_sym,  8'h22);
    checkOutput("d2_in_ready", if3.in_ready, 1);
    @(negedge clk);
    #1;
    checkOutput("d2_empty_valid", if3.out_valid, 0);
    checkOutput("d2_empty_busy",  if3.busy,      0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
